// File: rtl/vx_gpu_pkg.sv
// Shared types for the result merge slice: FSM states, pid width helper and
// the lane packet view at the default configuration.
package vx_gpu_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } merge_state_t;

   function automatic int unsigned pid_width(input int unsigned num_packets);
      int unsigned w;
      w = 1;
      if (num_packets > 1) w = $clog2(num_packets);
      return w;
   endfunction

   localparam int unsigned PKT_NUM_LANES = 1;
   localparam int unsigned PKT_XLEN      = 32;
   localparam int unsigned PKT_NW_WIDTH  = 2;
   localparam int unsigned PKT_META_W    = 16;
   localparam int unsigned PKT_PID_WIDTH = pid_width(4);

   typedef struct packed {
      logic [PKT_NW_WIDTH-1:0]           wid;
      logic [PKT_PID_WIDTH-1:0]          pid;
      logic                              sop;
      logic                              eop;
      logic [PKT_NUM_LANES-1:0]          tmask;
      logic [PKT_NUM_LANES*PKT_XLEN-1:0] data;
      logic [PKT_META_W-1:0]             meta;
   } merge_pkt_t;

endpackage

// File: rtl/vx_merge_lane_buf.sv
// One packet-wide slice of the warp record: mask and lane data, cleared when a
// new instruction starts unless this slice is the one being written.
module vx_merge_lane_buf #(
   parameter int unsigned NUM_LANES = 1,
   parameter int unsigned XLEN      = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clear,
   input  logic                      we,
   input  logic [NUM_LANES-1:0]      in_tmask,
   input  logic [NUM_LANES*XLEN-1:0] in_data,
   output logic [NUM_LANES-1:0]      tmask,
   output logic [NUM_LANES*XLEN-1:0] data
);

   always_ff @(posedge clk) begin
      if (reset) begin
         tmask <= '0;
         data  <= '0;
      end else if (we) begin
         tmask <= in_tmask;
         data  <= in_data;
      end else if (clear) begin
         tmask <= '0;
         data  <= '0;
      end
   end

endmodule

// File: rtl/vx_result_merge_unit.sv
// Reassembles lane packets of one instruction into a full-warp writeback record.
// Optional protocol checker (proto_err port) under VX_RESULT_MERGE_CHECK_EN.
module vx_result_merge_unit
   import vx_gpu_pkg::*;
#(
   parameter  int unsigned NUM_THREADS = 4,
   parameter  int unsigned NUM_LANES   = 1,
   parameter  int unsigned XLEN        = 32,
   parameter  int unsigned NW_WIDTH    = 2,
   parameter  int unsigned META_W      = 16,
   localparam int unsigned NUM_PACKETS = NUM_THREADS / NUM_LANES,
   localparam int unsigned PID_WIDTH   = pid_width(NUM_PACKETS)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [NW_WIDTH-1:0]         in_wid,
   input  logic [PID_WIDTH-1:0]        in_pid,
   input  logic                        in_sop,
   input  logic                        in_eop,
   input  logic [NUM_LANES-1:0]        in_tmask,
   input  logic [NUM_LANES*XLEN-1:0]   in_data,
   input  logic [META_W-1:0]           in_meta,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [NW_WIDTH-1:0]         out_wid,
   output logic [NUM_THREADS-1:0]      out_tmask,
   output logic [NUM_THREADS*XLEN-1:0] out_data,
   output logic [META_W-1:0]           out_meta,
   output logic [31:0]                 perf_merged
`ifdef VX_RESULT_MERGE_CHECK_EN
   ,
   output logic                        proto_err
`endif
);

   if (NUM_THREADS % NUM_LANES != 0) begin : g_bad_cfg
      $error("NUM_THREADS must be a multiple of NUM_LANES");
   end

   merge_state_t state, state_next, base_state;
   logic in_fire, out_fire, accept_sop, accept_cont, wr_en;

   assign out_valid = (state == FULL);
   assign in_ready  = (state != FULL) || out_ready;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   // A record draining this cycle frees the buffer, so the incoming packet sees IDLE
   assign base_state  = out_fire ? IDLE : state;
   assign accept_sop  = in_fire && in_sop;
   assign accept_cont = in_fire && !in_sop && (base_state == COLLECT);
   assign wr_en       = accept_sop || accept_cont;

   always_comb begin
      state_next = base_state;
      if (accept_sop)
         state_next = in_eop ? FULL : COLLECT;
      else if (accept_cont && in_eop)
         state_next = FULL;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         out_wid     <= '0;
         out_meta    <= '0;
         perf_merged <= '0;
      end else begin
         state <= state_next;
         if (accept_sop) begin
            out_wid  <= in_wid;
            out_meta <= in_meta;
         end
         if (out_fire) perf_merged <= perf_merged + 32'd1;
      end
   end

   for (genvar p = 0; p < NUM_PACKETS; p++) begin : g_slice
      logic sel;
      assign sel = (NUM_PACKETS == 1) || (in_pid == PID_WIDTH'(p));
      vx_merge_lane_buf #(
         .NUM_LANES (NUM_LANES),
         .XLEN      (XLEN)
      ) u_buf (
         .clk      (clk),
         .reset    (reset),
         .clear    (accept_sop),
         .we       (wr_en && sel),
         .in_tmask (in_tmask),
         .in_data  (in_data),
         .tmask    (out_tmask[p*NUM_LANES +: NUM_LANES]),
         .data     (out_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN])
      );
   end

`ifdef VX_RESULT_MERGE_CHECK_EN
   logic [PID_WIDTH-1:0] last_pid;
   logic                 err_set;

   always_comb begin
      err_set = 1'b0;
      if (in_fire) begin
         if (!in_sop && base_state != COLLECT) err_set = 1'b1;
         if (in_sop && base_state == COLLECT) err_set = 1'b1;
         if (accept_cont && ((in_wid != out_wid) ||
             ((NUM_PACKETS > 1) && (in_pid <= last_pid)))) err_set = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         proto_err <= 1'b0;
         last_pid  <= '0;
      end else begin
         if (err_set) proto_err <= 1'b1;
         if (wr_en) last_pid <= in_pid;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) assert (!(err_set && !proto_err));
   end
`endif

endmodule

// File: doc/vx_result_merge_unit.md
Name: vx_result_merge_unit

Overview:
- Sits downstream of an execute unit that receives lane-packetised work (NUM_LANES wide, pid/sop/eop tagged) from dispatch.
- Reassembles that unit's per-packet results into one full-warp (NUM_THREADS wide) writeback record before commit.
- Buffers one warp record and exposes valid/ready handshakes on both sides.

Parameters:
- NUM_THREADS, 4, threads per warp.
- NUM_LANES, 1, lanes per packet; NUM_THREADS % NUM_LANES == 0 (static assert).
- XLEN, 32, data width per lane.
- NW_WIDTH, 2, warp id width.
- META_W, 16, opaque metadata (uuid, rd, wb, PC) carried from the sop packet.
- Derived: NUM_PACKETS = NUM_THREADS/NUM_LANES; PID_WIDTH = max(1, clog2(NUM_PACKETS)).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  result packet valid
- in_ready  out  1  packet accepted when in_valid && in_ready
- in_wid  in  NW_WIDTH  warp id
- in_pid  in  PID_WIDTH  packet index
- in_sop  in  1  first packet of instruction
- in_eop  in  1  last packet of instruction
- in_tmask  in  NUM_LANES  lane mask of packet
- in_data  in  NUM_LANES*XLEN  lane results
- in_meta  in  META_W  metadata, sampled on sop only
- out_valid  out  1  merged record valid
- out_ready  in  1  commit accepts
- out_wid  out  NW_WIDTH
- out_tmask  out  NUM_THREADS  OR of all packet masks
- out_data  out  NUM_THREADS*XLEN  lane k = packet k/NUM_LANES, lane k%NUM_LANES
- out_meta  out  META_W
- perf_merged  out  32  count of records fired on output

Behaviour:
- Protocol: packets of one instruction arrive contiguously, strictly ascending pid, sop on first, eop on last. sop && eop is a single-packet instruction. Skipped pids (empty mask) never arrive.
- States:
  - IDLE: no assembly.
  - COLLECT: sop seen, eop not yet seen.
  - FULL: record complete, out_valid=1.
- Transitions:
  - IDLE -sop fire-> COLLECT, or -> FULL if eop also set.
  - COLLECT -fire with eop-> FULL.
  - FULL -out fire-> IDLE, or -> COLLECT / FULL if a new sop packet fires the same cycle.
- in_ready = (state != FULL) || out_ready. This gives full throughput, with a 1-cycle bubble-free handoff.
- Write on fire:
  - Lanes of slice in_pid take in_data.
  - out_tmask slice takes in_tmask.
  - On sop: all other tmask/data slices clear to 0, and wid/meta are captured.
- Latency: eop fire at cycle N -> out_valid at N+1.
- out_* hold stable while out_valid && !out_ready.
- Simultaneous output fire and sop fire: the output presents the old record this cycle; the new packet's write lands next cycle.
- Protocol violations:
  - Non-sop packet in IDLE: accepted and dropped.
  - sop in COLLECT: restarts assembly, discarding partial data.
  - wid mismatch in COLLECT: packet is still merged.
- perf_merged increments on each out fire, wrapping at 2^32.
- NUM_PACKETS==1: pid ignored; every packet must carry sop && eop.
- Reset, including mid-assembly:
  - state IDLE; out_valid 0; out_tmask/out_data/out_wid/out_meta 0; perf_merged 0.
  - Partial data is discarded.

Optional Feature:
- Macro VX_RESULT_MERGE_CHECK_EN.
- Defined:
  - Adds output proto_err (1 bit, sticky until reset).
  - Set on: non-sop in IDLE; sop in COLLECT; wid mismatch; pid not greater than previous pid.
  - Simulation assertion fires on the set edge.
- Undefined: no port, no checking logic; violation handling is otherwise identical.

Decomposition:
- Shared package (vx_gpu_pkg):
  - merge_state_t enum {IDLE, COLLECT, FULL}.
  - PID_WIDTH derivation function.
  - Packet record struct {wid, pid, sop, eop, tmask, data, meta}.
- Sub-module vx_merge_lane_buf: per-packet slice register with clear-on-sop and write-enable. Instantiated NUM_PACKETS times.

Test Plan:
- NUM_THREADS=4, NUM_LANES=1: pids 0,1,2,3 carrying data 0xA0..0xA3, masks all 1, sop on pid0, eop on pid3 -> one record, tmask 4'b1111, data {A3,A2,A1,A0}, out_valid 1 cycle after eop fire.
- Sparse warp: packets pid1 (sop, 0x11) and pid3 (eop, 0x33) -> tmask 4'b1010, lanes 0 and 2 equal 0.
- Backpressure: hold out_ready=0 for 5 cycles with the next sop pending -> in_ready=0, output stable. Then out_ready=1 -> old record fires and sop is accepted the same cycle; perf_merged=1.
- Back-to-back single-packet instructions (sop && eop, NUM_LANES=4) with out_ready=1 -> one record per cycle; perf_merged=8 after 8 records.
- Reset asserted after 2 of 4 packets, then a full new instruction -> no stale lanes, only the new record emitted.
- With VX_RESULT_MERGE_CHECK_EN: eop-only packet in IDLE -> dropped, proto_err=1 until reset.
